decode_stage: RTL and testbench

Pipelined, parametrised RV32I instruction decoder for the datapath's decode stage. Sits between fetch and register read and uses a valid/ready handshake instead of a state-gated enable. Covers all six base formats (R, I, S, B, U, J) and sign-extends immediates to XLEN. A two-entry skid buffer sustains one instruction per cycle under backpressure, and the block flags and counts illegal opcodes.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/decode_comb.sv | 64 ++++++
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, format codes,
// the decoded-entry record and the buffer state encoding.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] TIPO_R   = 3'd0;
    localparam logic [2:0] TIPO_I   = 3'd1;
    localparam logic [2:0] TIPO_S   = 3'd2;
    localparam logic [2:0] TIPO_B   = 3'd3;
    localparam logic [2:0] TIPO_U   = 3'd4;
    localparam logic [2:0] TIPO_J   = 3'd5;
    localparam logic [2:0] TIPO_ILL = 3'd7;

    // The immediate is held as a 32-bit two's-complement value; the top
    // sign-extends it to XLEN, which covers the U format on XLEN=64 too.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  tipo;
        logic        ilegal;
    } decoded_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction word to decoded-entry translation.
// Fields a format does not use are forced to zero.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instrucao,
    output decoded_t    dec
);

    logic [31:0] i;
    assign i = instrucao;

    // Format selection, field extraction and immediate assembly.
    always_comb begin
        dec        = '0;
        dec.opcode = i[6:0];
        case (i[6:0])
            OP_R: begin
                dec.tipo   = TIPO_R;
                dec.rd     = i[11:7];
                dec.rs1    = i[19:15];
                dec.rs2    = i[24:20];
                dec.funct3 = i[14:12];
                dec.funct7 = i[31:25];
            end
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                dec.tipo   = TIPO_I;
                dec.rd     = i[11:7];
                dec.rs1    = i[19:15];
                dec.funct3 = i[14:12];
                dec.imm    = {{20{i[31]}}, i[31:20]};
            end
            OP_STORE: begin
                dec.tipo   = TIPO_S;
                dec.rs1    = i[19:15];
                dec.rs2    = i[24:20];
                dec.funct3 = i[14:12];
                dec.imm    = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            OP_BRANCH: begin
                dec.tipo   = TIPO_B;
                dec.rs1    = i[19:15];
                dec.rs2    = i[24:20];
                dec.funct3 = i[14:12];
                dec.imm    = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.tipo   = TIPO_U;
                dec.rd     = i[11:7];
                dec.imm    = {i[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.tipo   = TIPO_J;
                dec.rd     = i[11:7];
                dec.imm    = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            default: begin
                dec.tipo   = TIPO_ILL;
                dec.ilegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with valid/ready handshake, a two-entry skid buffer
// holding already-decoded entries, and a saturating illegal-opcode counter.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | nothing buffered; in_ready=1, out_valid=0
//   ST_ONE   | main register holds the entry being presented
//   ST_TWO   | main and skid both full; in_ready=0
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instrucao,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imediato,
    output logic             negativo,
    output logic [2:0]       tipo,
    output logic             ilegal,
    output logic [CNT_W-1:0] cnt_ilegal
);

    decoded_t   dec_in;
    decoded_t   main_q, main_d;
    decoded_t   skid_q, skid_d;
    buf_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic       accept, pop, cnt_inc;

    decode_comb u_decode_comb (
        .instrucao (instrucao),
        .dec       (dec_in)
    );

    // in_ready depends only on registered state, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign cnt_inc   = accept && !flush && dec_in.ilegal && (cnt_q != {CNT_W{1'b1}});

    // Buffer next-state and data movement; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = dec_in;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d  = dec_in;
                    end else if (accept) begin
                        skid_d  = dec_in;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Illegal-instruction counter; survives flush, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign opcode     = main_q.opcode;
    assign rd         = main_q.rd;
    assign rs1        = main_q.rs1;
    assign rs2        = main_q.rs2;
    assign funct3     = main_q.funct3;
    assign funct7     = main_q.funct7;
    assign imediato   = XLEN'($signed(main_q.imm));
    assign negativo   = imediato[XLEN-1];
    assign tipo       = main_q.tipo;
    assign ilegal     = main_q.ilegal;
    assign cnt_ilegal = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes the hand-computed
// decode of every accepted word; a monitor pops on each output transfer.
module tb_decode_stage;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [2:0]  tipo;
        logic        il;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush_a, flush_b;
    logic        in_valid_a, in_valid_b, in_ready_a, in_ready_b;
    logic [31:0] instr_a, instr_b;
    logic        out_valid_a, out_valid_b, out_ready_a, out_ready_b;
    logic [6:0]  opcode_a, opcode_b, funct7_a, funct7_b;
    logic [4:0]  rd_a, rd_b, rs1_a, rs1_b, rs2_a, rs2_b;
    logic [2:0]  funct3_a, funct3_b, tipo_a, tipo_b;
    logic [31:0] imm_a;
    logic [63:0] imm_b;
    logic        neg_a, neg_b, ilegal_a, ilegal_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    decode_stage #(.XLEN(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .instrucao(instr_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .opcode(opcode_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a),
        .funct3(funct3_a), .funct7(funct7_a), .imediato(imm_a),
        .negativo(neg_a), .tipo(tipo_a), .ilegal(ilegal_a), .cnt_ilegal(cnt_a)
    );

    decode_stage #(.XLEN(64), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .instrucao(instr_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .opcode(opcode_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b),
        .funct3(funct3_b), .funct7(funct7_b), .imediato(imm_b),
        .negativo(neg_b), .tipo(tipo_b), .ilegal(ilegal_b), .cnt_ilegal(cnt_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] imm, input logic [2:0] tipo,
                                input logic il);
        exp_t e;
        e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7;
        e.imm = imm; e.tipo = tipo; e.il = il;
        return e;
    endfunction

    task automatic compare_entry(input string tag, input exp_t e, input exp_t a,
                                 input logic neg, input bit wide);
        chk({tag, ".opcode"}, 64'(a.op), 64'(e.op));
        chk({tag, ".rd"}, 64'(a.rd), 64'(e.rd));
        chk({tag, ".rs1"}, 64'(a.rs1), 64'(e.rs1));
        chk({tag, ".rs2"}, 64'(a.rs2), 64'(e.rs2));
        chk({tag, ".funct3"}, 64'(a.f3), 64'(e.f3));
        chk({tag, ".funct7"}, 64'(a.f7), 64'(e.f7));
        chk({tag, ".tipo"}, 64'(a.tipo), 64'(e.tipo));
        chk({tag, ".ilegal"}, 64'(a.il), 64'(e.il));
        if (wide) begin
            chk({tag, ".imediato"}, a.imm, e.imm);
            chk({tag, ".negativo"}, 64'(neg), 64'(e.imm[63]));
        end else begin
            chk({tag, ".imediato"}, {32'b0, a.imm[31:0]}, {32'b0, e.imm[31:0]});
            chk({tag, ".negativo"}, 64'(neg), 64'(e.imm[31]));
        end
    endtask

    // Monitor: every output transfer must match the oldest expected entry.
    exp_t act_a, act_b, e_a, e_b;
    always @(negedge clk) begin
        if (out_valid_a && out_ready_a) begin
            act_a = mk(opcode_a, rd_a, rs1_a, rs2_a, funct3_a, funct7_a,
                       {32'b0, imm_a}, tipo_a, ilegal_a);
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_a: got opcode %0h with empty scoreboard", opcode_a);
            end else begin
                e_a = q_a.pop_front();
                compare_entry("a", e_a, act_a, neg_a, 1'b0);
            end
        end
        if (out_valid_b && out_ready_b) begin
            act_b = mk(opcode_b, rd_b, rs1_b, rs2_b, funct3_b, funct7_b,
                       imm_b, tipo_b, ilegal_b);
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_b: got opcode %0h with empty scoreboard", opcode_b);
            end else begin
                e_b = q_b.pop_front();
                compare_entry("b", e_b, act_b, neg_b, 1'b1);
            end
        end
    end

    // Offer one word; returns one time unit after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] w, input exp_t e, output int stalls);
        int   n = 0;
        bit   done = 0;
        logic rdy, fl;
        if (sel) begin in_valid_b = 1'b1; instr_b = w; end
        else     begin in_valid_a = 1'b1; instr_a = w; end
        while (!done && n < 50) begin
            @(negedge clk);
            rdy = sel ? in_ready_b : in_ready_a;
            fl  = sel ? flush_b : flush_a;
            @(posedge clk); #1;
            if (rdy) begin
                done = 1;
                if (!fl) begin
                    if (sel) q_b.push_back(e);
                    else     q_a.push_back(e);
                end
            end else begin
                n++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %08h not accepted after %0d cycles", w, n);
        end
        stalls = n;
        if (sel) in_valid_b = 1'b0; else in_valid_a = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    exp_t e_addi, e_beq, e_lui, e_jal, e_sub, e_sw, e_ill, e_lui64, e_addi64;
    int   st;

    initial begin
        e_addi   = mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFB, 3'd1, 1'b0);
        e_beq    = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
        e_lui    = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
        e_jal    = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0000_0800, 3'd5, 1'b0);
        e_sub    = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'h0, 3'd0, 1'b0);
        e_sw     = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        e_ill    = mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0, 3'd7, 1'b1);
        e_lui64  = mk(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        e_addi64 = e_addi;

        rst_n = 1'b1;
        flush_a = 0; flush_b = 0; in_valid_a = 0; in_valid_b = 0;
        instr_a = '0; instr_b = '0; out_ready_a = 0; out_ready_b = 0;
        #2 rst_n = 1'b0;
        #5;
        chk("rst.out_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst.in_ready_a", 64'(in_ready_a), 64'd1);
        chk("rst.cnt_a", 64'(cnt_a), 64'd0);
        chk("rst.imm_a", 64'(imm_a), 64'd0);
        chk("rst.tipo_a", 64'(tipo_a), 64'd0);
        chk("rst.out_valid_b", 64'(out_valid_b), 64'd0);
        chk("rst.imm_b", imm_b, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Streaming with the consumer always ready: one per cycle, no stalls.
        out_ready_a = 1'b1;
        send(0, 32'hFFB10093, e_addi, st);
        chk("lat.out_valid", 64'(out_valid_a), 64'd1);
        chk("stream.stall0", 64'(st), 64'd0);
        send(0, 32'hFE208CE3, e_beq, st); chk("stream.stall1", 64'(st), 64'd0);
        send(0, 32'h123452B7, e_lui, st); chk("stream.stall2", 64'(st), 64'd0);
        send(0, 32'h001000EF, e_jal, st); chk("stream.stall3", 64'(st), 64'd0);
        send(0, 32'h402081B3, e_sub, st); chk("stream.stall4", 64'(st), 64'd0);
        send(0, 32'hFE20AE23, e_sw,  st); chk("stream.stall5", 64'(st), 64'd0);
        wait_cycles(3);

        // Illegal words and the counter.
        send(0, 32'h00000000, e_ill, st);
        send(0, 32'h00000000, e_ill, st);
        wait_cycles(2);
        chk("ill.cnt2", 64'(cnt_a), 64'd2);
        send(0, 32'hFFFFFF80, e_ill, st);
        wait_cycles(2);
        chk("ill.cnt3", 64'(cnt_a), 64'd3);

        // Backpressure: two accepted, third held off, then drain in order.
        out_ready_a = 1'b0;
        send(0, 32'hFFB10093, e_addi, st); chk("bp.stall0", 64'(st), 64'd0);
        send(0, 32'h123452B7, e_lui, st);  chk("bp.stall1", 64'(st), 64'd0);
        in_valid_a = 1'b1; instr_a = 32'h001000EF;
        @(negedge clk);
        chk("bp.in_ready_full", 64'(in_ready_a), 64'd0);
        chk("bp.out_valid_full", 64'(out_valid_a), 64'd1);
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        fork
            send(0, 32'h001000EF, e_jal, st);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk($sformatf("bp.drain_valid%0d", k), 64'(out_valid_a), 64'd1);
                end
            end
        join
        chk("bp.third_stall", 64'(st), 64'd1);
        wait_cycles(3);

        // Flush while ONE with a same-cycle transfer that must be dropped.
        out_ready_a = 1'b0;
        send(0, 32'hFE208CE3, e_beq, st);
        flush_a = 1'b1; in_valid_a = 1'b1; instr_a = 32'h00000000;
        @(posedge clk); #1;
        flush_a = 1'b0; in_valid_a = 1'b0;
        q_a.delete();
        chk("flush1.out_valid", 64'(out_valid_a), 64'd0);
        chk("flush1.in_ready", 64'(in_ready_a), 64'd1);
        chk("flush1.cnt", 64'(cnt_a), 64'd3);

        // Flush while TWO.
        send(0, 32'hFE208CE3, e_beq, st);
        send(0, 32'hFE20AE23, e_sw, st);
        flush_a = 1'b1; in_valid_a = 1'b1; instr_a = 32'h00000000;
        @(posedge clk); #1;
        flush_a = 1'b0; in_valid_a = 1'b0;
        q_a.delete();
        chk("flush2.out_valid", 64'(out_valid_a), 64'd0);
        chk("flush2.in_ready", 64'(in_ready_a), 64'd1);
        chk("flush2.cnt", 64'(cnt_a), 64'd3);
        out_ready_a = 1'b1;
        wait_cycles(3);

        // XLEN=64 instance: sign-extended U immediate and 2-bit saturation.
        out_ready_b = 1'b1;
        send(1, 32'h800000B7, e_lui64, st);
        send(1, 32'hFFB10093, e_addi64, st);
        for (int k = 0; k < 5; k++) send(1, 32'h00000000, e_ill, st);
        wait_cycles(2);
        chk("sat.cnt_b", 64'(cnt_b), 64'd3);

        // Asynchronous reset in the middle of a buffered stream.
        out_ready_a = 1'b0;
        send(0, 32'hFFB10093, e_addi, st);
        send(0, 32'h123452B7, e_lui, st);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(out_valid_a), 64'd0);
        chk("arst.in_ready", 64'(in_ready_a), 64'd1);
        chk("arst.cnt", 64'(cnt_a), 64'd0);
        chk("arst.rd", 64'(rd_a), 64'd0);
        chk("arst.imm", 64'(imm_a), 64'd0);
        chk("arst.tipo", 64'(tipo_a), 64'd0);
        chk("arst.cnt_b", 64'(cnt_b), 64'd0);
        q_a.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready_a = 1'b1;
        send(0, 32'h001000EF, e_jal, st);
        chk("arst.first_stall", 64'(st), 64'd0);
        wait_cycles(3);

        chk("end.q_a_empty", 64'(q_a.size()), 64'd0);
        chk("end.q_b_empty", 64'(q_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
